// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and frame builder.
`timescale 1ns/1ps
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_ACK,
    ST_WAITIDLE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Shifted out LSB first: D0..D7, odd parity, stop (released line).
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus clock falling-edge pulse.
`timescale 1ns/1ps
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2c_o,
  output logic ps2d_o,
  output logic fall_o
);

  logic [1:0] c_q;
  logic [1:0] d_q;
  logic       c_prev_q;

  // Idle bus level is high, so flops reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q      <= '1;
      d_q      <= '1;
      c_prev_q <= 1'b1;
    end else begin
      c_q      <= {c_q[0], ps2c_i};
      d_q      <= {d_q[0], ps2d_i};
      c_prev_q <= c_q[1];
    end
  end

  assign ps2c_o = c_q[1];
  assign ps2d_o = d_q[1];
  assign fall_o = c_prev_q & ~c_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; only pulls the open-drain lines low.
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned INHIBIT_CYCLES = 6_000,
  parameter int unsigned TIMEOUT_CYCLES = 750_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  // Inhibit must last at least 100 us and share the watchdog counter.
  if (64'(INHIBIT_CYCLES) * 64'd10_000 < 64'(CLK_HZ)) begin : g_chk_inh
    $error("INHIBIT_CYCLES shorter than 100 us");
  end
  if (INHIBIT_CYCLES >= TIMEOUT_CYCLES || INHIBIT_CYCLES == 0) begin : g_chk_cnt
    $error("INHIBIT_CYCLES must be nonzero and below TIMEOUT_CYCLES");
  end

  logic c_sync, d_sync, fall;

  ps2_line_sync u_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .ps2c_i (ps2c_in),
    .ps2d_i (ps2d_in),
    .ps2c_o (c_sync),
    .ps2d_o (d_sync),
    .fall_o (fall)
  );

  ps2_tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic          dout_q, dout_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          inh_last, timeout;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      bitcnt_q <= '0;
      dout_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign inh_last = (cnt_q == CW'(INHIBIT_CYCLES - 1));
  assign timeout  = !fall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d  = ST_INHIBIT;
          cnt_d    = '0;
          sh_d     = ps2_frame(tx_data);
          bitcnt_d = '0;
          dout_d   = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (inh_last) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          dout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REQ, ST_ACK, ST_WAITIDLE: begin
        cnt_d = fall ? '0 : cnt_q + CW'(1);
        if (timeout) begin
          state_d = ST_IDLE;
          dout_d  = 1'b0;
          err_d   = 1'b1;
        end else if (state_q == ST_REQ) begin
          if (fall) begin
            dout_d   = ~sh_q[0];
            sh_d     = {1'b1, sh_q[9:1]};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) state_d = ST_ACK;
          end
        end else if (state_q == ST_ACK) begin
          if (fall) begin
            if (!d_sync) begin
              state_d = ST_WAITIDLE;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end
        end else if (c_sync && d_sync) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ps2c_oe = (state_q == ST_INHIBIT);
    ps2d_oe = ((state_q == ST_INHIBIT) && inh_last) || ((state_q == ST_REQ) && dout_q);
    tx_busy = (state_q != ST_IDLE);
    tx_done = done_q;
    tx_err  = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INH  = 60;
  localparam int unsigned TO   = 400;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2c_oe, ps2d_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2c_in, ps2d_in;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_data & ~ps2d_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ         (500_000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe)
  );

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) err_cnt++;
    if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt++;
  end

  // Device model: clocks 11 falls, samples data on each rise, optionally ACKs.
  task automatic run_frame(input logic [7:0] data, input bit ack, input int mid_bit,
                           input int rst_bit, output logic [9:0] frame, output logic start_bit,
                           output int inh_len, output logic d_at_rel, output bit timed_out);
    int n;
    frame = '0; start_bit = 1'b1; inh_len = 0; d_at_rel = 1'b0; timed_out = 0;
    @(negedge clk); tx_data = data; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    n = 0;
    while (ps2c_oe !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    if (n >= 10) begin timed_out = 1; return; end
    while (ps2c_oe === 1'b1 && inh_len < int'(INH) + 100) begin inh_len++; @(negedge clk); end
    d_at_rel = ps2d_oe;
    repeat (5) @(negedge clk);
    start_bit = ps2d_in;
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      if (i == rst_bit) begin
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        return;
      end
      if (i == mid_bit) begin
        repeat (4) @(negedge clk);
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0; tx_data = data;
        repeat (HALF - 5) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b1;
      frame[i] = ps2d_in;
      repeat (HALF) @(negedge clk);
    end
    if (ack) dev_data = 1'b0;
    repeat (2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_data = 1'b1;
    n = 0;
    while (tx_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timed_out = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
    total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", tx_err); end
    total++; if (ps2c_oe !== 1'b0) begin bad++; $display("FAIL reset_c_oe: got %b want 0", ps2c_oe); end
    total++; if (ps2d_oe !== 1'b0) begin bad++; $display("FAIL reset_d_oe: got %b want 0", ps2d_oe); end
  endtask

  task automatic test_set_led();
    logic [9:0] fr; logic sb, dr; int inh; bit to; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(PS2_CMD_SET_LED, 1, -1, -1, fr, sb, inh, dr, to);
    total++; if (to) begin bad++; $display("FAIL led_timeout: got stuck want complete"); end
    total++; if (inh != int'(INH)) begin bad++; $display("FAIL led_inhibit_len: got %0d want %0d", inh, INH); end
    total++; if (dr !== 1'b1) begin bad++; $display("FAIL led_start_before_release: got %b want 1", dr); end
    total++; if (sb !== 1'b0) begin bad++; $display("FAIL led_start_bit: got %b want 0", sb); end
    total++; if (fr !== 10'h3ED) begin bad++; $display("FAIL led_frame: got %h want 3ed", fr); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL led_done: got %0d want 1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL led_err: got %0d want 0", err_cnt - e0); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL led_busy_after: got %b want 0", tx_busy); end
  endtask

  task automatic test_parity();
    logic [9:0] fr; logic sb, dr; int inh; bit to; int d0;
    d0 = done_cnt;
    run_frame(8'h00, 1, -1, -1, fr, sb, inh, dr, to);
    total++; if (fr !== 10'h300 || to) begin bad++; $display("FAIL parity_00: got %h want 300", fr); end
    run_frame(8'h01, 1, -1, -1, fr, sb, inh, dr, to);
    total++; if (fr !== 10'h201 || to) begin bad++; $display("FAIL parity_01: got %h want 201", fr); end
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL parity_done: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_no_ack();
    logic [9:0] fr; logic sb, dr; int inh; bit to; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(PS2_CMD_ENABLE, 0, -1, -1, fr, sb, inh, dr, to);
    total++; if (err_cnt - e0 != 1 || to) begin bad++; $display("FAIL noack_err: got %0d want 1", err_cnt - e0); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL noack_done: got %0d want 0", done_cnt - d0); end
    total++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin
      bad++; $display("FAIL noack_lines: got c=%b d=%b want 0 0", ps2c_oe, ps2d_oe); end
  endtask

  task automatic test_timeout();
    int n; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk); tx_data = PS2_CMD_RESET; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    n = 0;
    while (ps2c_oe !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (ps2c_oe === 1'b1 && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (tx_err !== 1'b1 && n < int'(TO) + 50) begin @(negedge clk); n++; end
    total++; if (n != int'(TO)) begin bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, TO); end
    total++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0 || tx_busy !== 1'b0) begin
      bad++; $display("FAIL timeout_release: got c=%b d=%b busy=%b want 0 0 0", ps2c_oe, ps2d_oe, tx_busy); end
    repeat (3) @(negedge clk);
    total++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      bad++; $display("FAIL timeout_pulses: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr; logic sb, dr; int inh; bit to; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(PS2_CMD_SET_LED, 1, 3, -1, fr, sb, inh, dr, to);
    total++; if (fr !== 10'h3ED || to) begin bad++; $display("FAIL b2b_frame: got %h want 3ed", fr); end
    total++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      bad++; $display("FAIL b2b_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_no_queue: got busy %b want 0", tx_busy); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] fr; logic sb, dr; int inh; bit to; int d0, e0;
    e0 = err_cnt;
    run_frame(PS2_CMD_SET_LED, 1, -1, 4, fr, sb, inh, dr, to);
    #1;
    total++; if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin
      bad++; $display("FAIL rstmid_lines: got c=%b d=%b want 0 0", ps2c_oe, ps2d_oe); end
    total++; if (tx_busy !== 1'b0 || tx_err !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags: got busy=%b err=%b want 0 0", tx_busy, tx_err); end
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL rstmid_no_err: got %0d want 0", err_cnt - e0); end
    d0 = done_cnt;
    run_frame(PS2_CMD_ENABLE, 1, -1, -1, fr, sb, inh, dr, to);
    total++; if (fr !== 10'h2F4 || to) begin bad++; $display("FAIL rstmid_f4_frame: got %h want 2f4", fr); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rstmid_f4_done: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_set_led();
    test_parity();
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
